// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to a
// variable-latency instruction memory and hands the word to the control unit.
`timescale 1ns/1ps
module fetch_unit #(
   parameter int                         ADDRESS_WIDTH = 32,
   parameter int                         DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
   parameter int                         TIMEOUT       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   input  logic                     imem_valid,
   input  logic                     stall,
   input  logic                     PCsrc,
   input  logic [ADDRESS_WIDTH-1:0] ImmOp,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic                     instr_valid,
   output logic [ADDRESS_WIDTH-1:0] PC,
   output logic [31:0]              retired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                   state_reg, state_next;
   logic [CW-1:0]            cnt_reg, cnt_next;
   logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
   logic [DATA_WIDTH-1:0]    instr_reg, instr_next;
   logic                     instr_valid_reg, instr_valid_next;
   logic [31:0]              retired_reg, retired_next;
   logic [ADDRESS_WIDTH-1:0] branch_sum;

   assign branch_sum = pc_reg + ImmOp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_REQ;
         cnt_reg         <= '0;
         pc_reg          <= RESET_PC;
         instr_reg       <= '0;
         instr_valid_reg <= 1'b0;
         retired_reg     <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         pc_reg          <= pc_next;
         instr_reg       <= instr_next;
         instr_valid_reg <= instr_valid_next;
         retired_reg     <= retired_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      pc_next          = pc_reg;
      instr_next       = instr_reg;
      instr_valid_next = instr_valid_reg;
      retired_next     = retired_reg;
      case (state_reg)
         S_REQ: begin
            cnt_next   = '0;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (imem_valid) begin
               instr_next       = imem_rdata;
               instr_valid_next = 1'b1;
               state_next       = S_HOLD;
            end else begin
               // The counter lands on TIMEOUT-1 at the re-issue edge, giving a
               // request period of exactly TIMEOUT cycles.
               cnt_next = cnt_reg + CW'(1);
               if (cnt_reg == CW'(TIMEOUT - 2))
                  state_next = S_REQ;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               pc_next          = PCsrc ? {branch_sum[ADDRESS_WIDTH-1:2], 2'b00}
                                        : pc_reg + ADDRESS_WIDTH'(4);
               retired_next     = retired_reg + 32'd1;
               instr_valid_next = 1'b0;
               state_next       = S_REQ;
            end
         end
         default: state_next = S_REQ;
      endcase
   end

   assign imem_req    = (state_reg == S_REQ) && !rst;
   assign imem_addr   = pc_reg;
   assign instr       = instr_reg;
   assign instr_valid = instr_valid_reg;
   assign PC          = pc_reg;
   assign retired     = retired_reg;

endmodule
